// File: rtl/nonblocking_pkg.sv
// Shared width default and word type for the nonblocking_swap cell.
package nonblocking_pkg;

  localparam int DEFAULT_WIDTH = 1;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage : nonblocking_pkg

// File: rtl/nb_swap_reg.sv
// One WIDTH-bit register with a synchronous load mux.
// load=1 captures load_d; load=0 captures swap_d.
module nb_swap_reg
  import nonblocking_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] load_d,
  input  logic [WIDTH-1:0] swap_d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = swap_d;
    if (load) q_d = load_d;
  end

  // No constant reset value: the load strobe is the only initialisation path.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule : nb_swap_reg

// File: rtl/nonblocking_swap.sv
// Two-register swap cell: rst loads a_i/b_i, otherwise the registers exchange each edge.
// Build option BLOCKING_ORDER_EN: both registers take the old B value instead of swapping.
module nonblocking_swap
  import nonblocking_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_swap_d;

`ifdef BLOCKING_ORDER_EN
  // Sequential-order model: B sees A's freshly written value, which is old B.
  assign b_swap_d = b_q;
`else
  assign b_swap_d = a_q;
`endif

  nb_swap_reg #(.WIDTH(WIDTH)) u_reg_a (
    .clk    (clk),
    .load   (rst),
    .load_d (a_i),
    .swap_d (b_q),
    .q      (a_q)
  );

  nb_swap_reg #(.WIDTH(WIDTH)) u_reg_b (
    .clk    (clk),
    .load   (rst),
    .load_d (b_i),
    .swap_d (b_swap_d),
    .q      (b_q)
  );

  assign a_o = a_q;
  assign b_o = b_q;

endmodule : nonblocking_swap

// File: tb/tb_nonblocking_swap.sv
// Directed bench for nonblocking_swap: 1-bit hand sequences plus an 8-bit vector table.
module tb_nonblocking_swap;

`ifdef BLOCKING_ORDER_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst1, a1, b1, ao1, bo1;
  logic       rst8;
  logic [7:0] a8, b8, ao8, bo8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ea;
    logic [7:0] eb;
  } vec_t;

  vec_t vecs [10];

  nonblocking_swap #(.WIDTH(1)) dut1 (
    .clk (clk), .rst (rst1), .a_i (a1), .b_i (b1), .a_o (ao1), .b_o (bo1)
  );

  nonblocking_swap #(.WIDTH(8)) dut8 (
    .clk (clk), .rst (rst8), .a_i (a8), .b_i (b8), .a_o (ao8), .b_o (bo8)
  );

  task automatic chk(input string nm, input logic [7:0] ga, input logic [7:0] gb,
                     input logic [7:0] ea, input logic [7:0] eb);
    total++;
    if (ga !== ea || gb !== eb) begin
      bad++;
      $display("FAIL %s: got a=%h b=%h, want a=%h b=%h", nm, ga, gb, ea, eb);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    rst8 = 1'b1; a8 = 8'hA5; b8 = 8'h3C;

    if (!BLK) begin
      vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vecs[1] = '{1'b0, 8'hFF, 8'h00, 8'h3C, 8'hA5};
      vecs[2] = '{1'b0, 8'h11, 8'h22, 8'hA5, 8'h3C};
      vecs[3] = '{1'b0, 8'h11, 8'h22, 8'h3C, 8'hA5};
      vecs[4] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF};
      vecs[5] = '{1'b1, 8'h12, 8'h34, 8'h12, 8'h34};
      vecs[6] = '{1'b0, 8'h99, 8'h66, 8'h34, 8'h12};
      vecs[7] = '{1'b1, 8'h77, 8'h77, 8'h77, 8'h77};
      vecs[8] = '{1'b0, 8'h01, 8'h02, 8'h77, 8'h77};
      vecs[9] = '{1'b0, 8'h01, 8'h02, 8'h77, 8'h77};
    end else begin
      vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vecs[1] = '{1'b0, 8'hFF, 8'h00, 8'h3C, 8'h3C};
      vecs[2] = '{1'b0, 8'h11, 8'h22, 8'h3C, 8'h3C};
      vecs[3] = '{1'b0, 8'h11, 8'h22, 8'h3C, 8'h3C};
      vecs[4] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF};
      vecs[5] = '{1'b1, 8'h12, 8'h34, 8'h12, 8'h34};
      vecs[6] = '{1'b0, 8'h99, 8'h66, 8'h34, 8'h34};
      vecs[7] = '{1'b1, 8'h77, 8'h77, 8'h77, 8'h77};
      vecs[8] = '{1'b0, 8'h01, 8'h02, 8'h77, 8'h77};
      vecs[9] = '{1'b0, 8'h01, 8'h02, 8'h77, 8'h77};
    end

    // Load (1,0) across one edge
    tick();
    chk("load1", {7'b0, ao1}, {7'b0, bo1}, 8'd1, 8'd0);

    // Swap for 5 edges with inputs held at different values
    rst1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (BLK) chk($sformatf("swap_e%0d", i + 1), {7'b0, ao1}, {7'b0, bo1}, 8'd0, 8'd0);
      else     chk($sformatf("swap_e%0d", i + 1), {7'b0, ao1}, {7'b0, bo1},
                   (i % 2 == 0) ? 8'd0 : 8'd1, (i % 2 == 0) ? 8'd1 : 8'd0);
    end

    // Inputs toggling every 3 ns while swapping must have no effect
    fork
      begin
        for (int k = 0; k < 26; k++) begin
          #3;
          a1 = ~a1;
          b1 = ~b1;
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          tick();
          if (BLK) chk($sformatf("iso_e%0d", j + 1), {7'b0, ao1}, {7'b0, bo1}, 8'd0, 8'd0);
          else     chk($sformatf("iso_e%0d", j + 1), {7'b0, ao1}, {7'b0, bo1},
                       (j % 2 == 0) ? 8'd1 : 8'd0, (j % 2 == 0) ? 8'd0 : 8'd1);
        end
      end
    join

    // Mid-run reload with (0,1), then swap resumes from the loaded state
    rst1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    tick();
    chk("midrst_load", {7'b0, ao1}, {7'b0, bo1}, 8'd0, 8'd1);
    rst1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
    tick();
    chk("midrst_e1", {7'b0, ao1}, {7'b0, bo1}, BLK ? 8'd1 : 8'd1, BLK ? 8'd1 : 8'd0);
    tick();
    chk("midrst_e2", {7'b0, ao1}, {7'b0, bo1}, BLK ? 8'd1 : 8'd0, BLK ? 8'd1 : 8'd1);

    // Equal inputs: outputs hold after reset
    rst1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    tick();
    rst1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    tick();
    chk("equal_hold", {7'b0, ao1}, {7'b0, bo1}, 8'd1, 8'd1);

    // 8-bit vector table
    for (int v = 0; v < 10; v++) begin
      rst8 = vecs[v].rst;
      a8   = vecs[v].a;
      b8   = vecs[v].b;
      tick();
      chk($sformatf("w8_v%0d", v), ao8, bo8, vecs[v].ea, vecs[v].eb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nonblocking_swap
